// File: rtl/enum_fsm_bank.sv
// -----------------------------------------------------------------------------
// enum_fsm_bank
//
// Bank of NCH independent 3-state rotor FSMs (FOO -> BAR -> BAZ -> FOO).
// Each channel sits in its own generate scope and declares its own
// enum { FOO, BAR, BAZ } with a channel-specific encoding:
//   FOO = k%3, BAR = (k+1)%3, BAZ = (k+2)%3   (encoding 3 is unused)
// so identical enum names coexist in sibling scopes.
//
// Every channel also keeps a saturating counter of entries into BAZ and
// produces a one-cycle wrap pulse after an advance from BAZ to FOO.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   en         in   1        global enable; 0 holds every channel (loads too)
//   cmd        in   2*NCH    channel k at [2k+1:2k]:
//                            00 hold, 01 advance, 10 retreat, 11 load
//   state_out  out  2*NCH    registered enum value, channel k at [2k+1:2k]
//   cnt_out    out  CW*NCH   BAZ-entry counter, channel k at [CW*k+CW-1:CW*k]
//   wrap       out  NCH      registered pulse: advance taken from BAZ to FOO
//   sat        out  NCH      counter of channel k equals 2^CW-1
//
// There is no handshake: a command is sampled on every rising edge where
// en is 1, and its effect is visible on the outputs one cycle later.
// No combinational path exists from cmd or en to any output.
// -----------------------------------------------------------------------------
module enum_fsm_bank #(
    parameter int NCH = 4,
    parameter int CW  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [2*NCH-1:0]  cmd,
    output logic [2*NCH-1:0]  state_out,
    output logic [CW*NCH-1:0] cnt_out,
    output logic [NCH-1:0]    wrap,
    output logic [NCH-1:0]    sat
);

    localparam logic [1:0] CMD_HOLD    = 2'b00;
    localparam logic [1:0] CMD_ADVANCE = 2'b01;
    localparam logic [1:0] CMD_RETREAT = 2'b10;
    localparam logic [1:0] CMD_LOAD    = 2'b11;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    for (genvar k = 0; k < NCH; k++) begin : g_ch

        // Channel-specific encoding of the shared enum names.
        localparam logic [1:0] L_FOO = 2'(k % 3);
        localparam logic [1:0] L_BAR = 2'((k + 1) % 3);
        localparam logic [1:0] L_BAZ = 2'((k + 2) % 3);

        typedef enum logic [1:0] {
            FOO = L_FOO,
            BAR = L_BAR,
            BAZ = L_BAZ
        } state_t;

        state_t          r_state;
        logic [CW-1:0]   r_cnt;
        logic            r_wrap;

        logic [1:0]      w_cmd;
        state_t          w_next;
        logic            w_enter_baz;
        logic            w_wrap_set;
        logic            w_clear_cnt;

        assign w_cmd = cmd[2*k +: 2];

        // Next-state decode. Any state value outside FOO/BAR/BAZ (only
        // reachable through upsets) falls to FOO with no count and no wrap,
        // whatever the command is.
        always_comb begin
            w_next      = r_state;
            w_enter_baz = 1'b0;
            w_wrap_set  = 1'b0;
            w_clear_cnt = 1'b0;
            case (w_cmd)
                CMD_LOAD: begin
                    w_next      = FOO;
                    w_clear_cnt = 1'b1;
                end
                CMD_ADVANCE: begin
                    case (r_state)
                        FOO: w_next = BAR;
                        BAR: begin
                            w_next      = BAZ;
                            w_enter_baz = 1'b1;
                        end
                        BAZ: begin
                            w_next     = FOO;
                            w_wrap_set = 1'b1;
                        end
                        default: w_next = FOO;
                    endcase
                end
                CMD_RETREAT: begin
                    case (r_state)
                        FOO: begin
                            w_next      = BAZ;
                            w_enter_baz = 1'b1;
                        end
                        BAZ:     w_next = BAR;
                        BAR:     w_next = FOO;
                        default: w_next = FOO;
                    endcase
                end
                default: begin
                    // CMD_HOLD: keep the state unless it is illegal.
                    case (r_state)
                        FOO, BAR, BAZ: w_next = r_state;
                        default:       w_next = FOO;
                    endcase
                end
            endcase
        end

        // State, counter and wrap registers. With en low the channel holds
        // and the wrap pulse is dropped.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= FOO;
                r_cnt   <= '0;
                r_wrap  <= 1'b0;
            end else if (!en) begin
                r_wrap  <= 1'b0;
            end else begin
                r_state <= w_next;
                r_wrap  <= w_wrap_set;
                if (w_clear_cnt) begin
                    r_cnt <= '0;
                end else if (w_enter_baz && (r_cnt != CNT_MAX)) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end
        end

        assign state_out[2*k +: 2]  = r_state;
        assign cnt_out[CW*k +: CW]  = r_cnt;
        assign wrap[k]              = r_wrap;
        assign sat[k]               = (r_cnt == CNT_MAX);
    end

endmodule
